// File: rtl/irt_dep_scan_if.sv
// Table-write, query and result bundle for the dependency scanner.
// The slave side is the scanner; the master side is the issue logic driving it.
interface irt_dep_scan_if #(
  parameter int regnum = 32,
  parameter int bs     = 16
);
  localparam int IW = $clog2(bs);

  logic              wr_en;
  logic [IW-1:0]     wr_index;
  logic [regnum-1:0] wr_rs_mask;
  logic [regnum-1:0] wr_rd_mask;
  logic              clr_en;
  logic [IW-1:0]     clr_index;
  logic [IW-1:0]     head;
  logic              q_valid;
  logic              q_ready;
  logic [IW-1:0]     q_index;
  logic              r_valid;
  logic              r_ready;
  logic [bs-1:0]     dep_vec;
  logic              raw_any;
  logic              war_any;
  logic              waw_any;

  modport slave (
    input  wr_en, wr_index, wr_rs_mask, wr_rd_mask, clr_en, clr_index, head,
    input  q_valid, q_index, r_ready,
    output q_ready, r_valid, dep_vec, raw_any, war_any, waw_any
  );

  modport master (
    output wr_en, wr_index, wr_rs_mask, wr_rd_mask, clr_en, clr_index, head,
    output q_valid, q_index, r_ready,
    input  q_ready, r_valid, dep_vec, raw_any, war_any, waw_any
  );
endinterface

// File: rtl/irt_dep_scan.sv
// Instruction-buffer dependency scanner: checks one queried entry against every
// older in-flight entry (circular from head), one entry per clock.
module irt_dep_scan #(
  parameter int regnum = 32,
  parameter int bs     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  irt_dep_scan_if.slave bus
);
  localparam int IW = $clog2(bs);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [bs-1:0]     valid_r;
  logic [regnum-1:0] rs_tab_r [bs];
  logic [regnum-1:0] rd_tab_r [bs];

  logic [IW-1:0]     q_idx_r;
  logic [IW-1:0]     ptr_r;
  logic [regnum-1:0] q_rs_r;
  logic [regnum-1:0] q_rd_r;
  logic [bs-1:0]     dep_vec_r;
  logic              raw_r;
  logic              war_r;
  logic              waw_r;
  logic              q_ready_r;
  logic              r_valid_r;

  logic              accept_s;
  logic              scan_s;
  logic              last_s;
  logic              raw_s;
  logic              war_s;
  logic              waw_s;

  // The scan ends after the entry immediately older than the queried one
  assign last_s = (ptr_r == (q_idx_r - IDX_ONE));

  // Hazard classes of the entry under the scan pointer against the snapshot
  always_comb begin
    raw_s = 1'b0;
    war_s = 1'b0;
    waw_s = 1'b0;
    if (valid_r[ptr_r]) begin
      raw_s = |(rd_tab_r[ptr_r] & q_rs_r);
      war_s = |(rs_tab_r[ptr_r] & q_rd_r);
      waw_s = |(rd_tab_r[ptr_r] & q_rd_r);
    end else begin
      raw_s = 1'b0;
      war_s = 1'b0;
      waw_s = 1'b0;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    scan_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.q_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = (bus.q_index == bus.head) ? DONE : SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        scan_s = 1'b1;
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DONE: begin
        if (bus.r_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Query control, scan pointer and accumulated result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_idx_r   <= IDX_ZERO;
      ptr_r     <= IDX_ZERO;
      dep_vec_r <= {bs{1'b0}};
      raw_r     <= 1'b0;
      war_r     <= 1'b0;
      waw_r     <= 1'b0;
      q_ready_r <= 1'b1;
      r_valid_r <= 1'b0;
    end else begin
      q_ready_r <= (state_nxt_s == IDLE);
      r_valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        q_idx_r   <= bus.q_index;
        ptr_r     <= bus.head;
        dep_vec_r <= {bs{1'b0}};
        raw_r     <= 1'b0;
        war_r     <= 1'b0;
        waw_r     <= 1'b0;
      end else if (scan_s) begin
        ptr_r            <= ptr_r + IDX_ONE;
        dep_vec_r[ptr_r] <= raw_s | war_s | waw_s;
        raw_r            <= raw_r | raw_s;
        war_r            <= war_r | war_s;
        waw_r            <= waw_r | waw_s;
      end
    end
  end

  // Snapshot the queried entry so later rewrites of it cannot disturb the scan
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      q_rs_r <= rs_tab_r[bus.q_index];
      q_rd_r <= rd_tab_r[bus.q_index];
    end
  end

  // Valid bits: the set is applied after the clear so a same-entry write wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= {bs{1'b0}};
    end else begin
      if (bus.clr_en) begin
        valid_r[bus.clr_index] <= 1'b0;
      end
      if (bus.wr_en) begin
        valid_r[bus.wr_index] <= 1'b1;
      end
    end
  end

  // Register masks carry no reset; stale contents are masked by the valid bits
  always_ff @(posedge clk) begin
    if (rst_n && bus.wr_en) begin
      rs_tab_r[bus.wr_index] <= bus.wr_rs_mask;
      rd_tab_r[bus.wr_index] <= bus.wr_rd_mask;
    end
  end

  assign bus.q_ready = q_ready_r;
  assign bus.r_valid = r_valid_r;
  assign bus.dep_vec = dep_vec_r;
  assign bus.raw_any = raw_r;
  assign bus.war_any = war_r;
  assign bus.waw_any = waw_r;
endmodule
